silife_max7219_rx: RTL and testbench

- Receive-side decoder for the MAX7219 daisy-chain SPI stream that the silife display driver emits (cs, sck, mosi).
- Oversamples the three asynchronous SPI lines on clk and shifts in a full chain frame.
- On CS deassertion, splits the frame into per-device 16-bit commands and presents them one per cycle as a valid-strobed word stream.
- Used for on-chip display loopback, scoreboard capture in the top-level bench, and driving a mirror display from a second grid.

---
 rtl/silife_max7219_rx.sv | 101 ++++++++++
 tb/tb_silife_max7219_rx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx: decodes a MAX7219 daisy-chain SPI frame into per-device command words.
module silife_max7219_rx #(
  parameter int CHAIN = 16,
  parameter int SYNC_STAGES = 2,
  localparam int FB = 16 * CHAIN,
  localparam int CW = $clog2(FB + 2),
  localparam int DW = CHAIN > 1 ? $clog2(CHAIN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_spi_cs,
  input  logic          i_spi_sck,
  input  logic          i_spi_mosi,
  output logic          o_valid,
  output logic [DW-1:0] o_device,
  output logic [3:0]    o_addr,
  output logic [7:0]    o_data,
  output logic          o_frame_done,
  output logic          o_frame_error,
  output logic          o_busy
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] cs_q, sck_q, mosi_q;
  logic cs_h, sck_h, cs_s, sck_s, mosi_s, cs_fall, cs_rise, sck_rise;
  logic [FB-1:0] shift_q, frame_q, src;
  logic [CW-1:0] cnt;
  logic [DW-1:0] idx;
  logic [11:0] word;
  logic go, fire, last, err_nxt;
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign cs_fall = cs_h & ~cs_s;
  assign cs_rise = ~cs_h & cs_s;
  assign sck_rise = sck_s & ~sck_h & ~cs_s;
  // cs idles high, so the synchronizer resets to 1 to avoid a phantom edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= '1;
      sck_q <= '0;
      mosi_q <= '0;
      cs_h <= 1'b1;
      sck_h <= 1'b0;
    end else begin
      cs_q <= {cs_q[SYNC_STAGES-2:0], i_spi_cs};
      sck_q <= {sck_q[SYNC_STAGES-2:0], i_spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_spi_mosi};
      cs_h <= cs_s;
      sck_h <= sck_s;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt <= '0;
    end else begin
      if (sck_rise) shift_q <= {shift_q[FB-2:0], mosi_s};
      if (cs_fall) cnt <= '0;
      else if (sck_rise && cnt != CW'(FB + 1)) cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb state_nxt = state == IDLE ? (go && !last ? EMIT : IDLE) : (last ? IDLE : EMIT);
  // the first word comes straight from the shift register so it lands one clk after the cs edge
  always_comb begin
    go = state == IDLE && cs_rise && cnt == CW'(FB);
    fire = go || state == EMIT;
    last = idx == DW'(CHAIN - 1);
    src = state == IDLE ? shift_q : frame_q;
    word = src[16*idx +: 12];
    err_nxt = cs_rise && cnt != '0 && (state == EMIT || cnt != CW'(FB));
    o_busy = ~cs_s || state == EMIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      idx <= '0;
      o_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_error <= 1'b0;
      o_device <= '0;
      o_addr <= '0;
      o_data <= '0;
    end else begin
      if (go) frame_q <= shift_q;
      idx <= fire && !last ? idx + 1'b1 : '0;
      o_valid <= fire;
      o_frame_done <= fire && last;
      o_frame_error <= err_nxt;
      if (fire) begin
        o_device <= idx;
        o_addr <= word[11:8];
        o_data <= word[7:0];
      end
    end
  end
endmodule

// File: tb/tb_silife_max7219_rx.sv
// tb_silife_max7219_rx: directed checks of the MAX7219 frame decoder with 2- and 16-device chains.
module tb_silife_max7219_rx;
  logic clk = 0, reset = 1, cs = 1, sck = 0, mosi = 0, sel = 0;
  logic v2, d2, e2, b2, v16, d16, e16, b16;
  logic [0:0] dev2;
  logic [3:0] dev16, a2, a16;
  logic [7:0] dt2, dt16;
  logic [16:0] qw[$];
  int qc[$];
  int cyc = 0, ne = 0, nd = 0, tests = 0, fails = 0;
  logic [255:0] fa, fb;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  silife_max7219_rx #(.CHAIN(2)) dut2 (
    .clk(clk), .reset(reset), .i_spi_cs(sel ? 1'b1 : cs), .i_spi_sck(sel ? 1'b0 : sck),
    .i_spi_mosi(sel ? 1'b0 : mosi), .o_valid(v2), .o_device(dev2), .o_addr(a2), .o_data(dt2),
    .o_frame_done(d2), .o_frame_error(e2), .o_busy(b2));
  silife_max7219_rx #(.CHAIN(16)) dut16 (
    .clk(clk), .reset(reset), .i_spi_cs(sel ? cs : 1'b1), .i_spi_sck(sel ? sck : 1'b0),
    .i_spi_mosi(sel ? mosi : 1'b0), .o_valid(v16), .o_device(dev16), .o_addr(a16), .o_data(dt16),
    .o_frame_done(d16), .o_frame_error(e16), .o_busy(b16));
  always @(negedge clk) begin
    if (v2) begin qw.push_back({d2, 3'b0, dev2, a2, dt2}); qc.push_back(cyc); end
    if (v16) begin qw.push_back({d16, dev16, a16, dt16}); qc.push_back(cyc); end
    ne += int'(e2) + int'(e16);
    nd += int'(d2) + int'(d16);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr();
    qw.delete(); qc.delete(); ne = 0; nd = 0;
  endtask
  task automatic cs_low();
    cs = 0; w(4);
  endtask
  task automatic cs_high(input int gap);
    w(4); cs = 1; w(gap);
  endtask
  task automatic bits(input int n, input logic [255:0] d);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i]; sck = 0; w(4);
      sck = 1; w(4);
    end
    sck = 0;
  endtask
  function automatic logic [16:0] ew(input int dn, input int dev, input int a, input int dt);
    return {1'(dn), 4'(dev), 4'(a), 8'(dt)};
  endfunction
  initial begin
    fa = '0; fb = '0;
    for (int k = 0; k < 16; k++) begin
      fa[16*k +: 16] = 16'h0A0F;
      fb[16*k +: 16] = {4'h5, 4'((k % 8) + 1), 8'(k * 17)};
    end
    w(5);
    chk("rst_valid", {31'b0, v2}, 0);
    chk("rst_busy", {31'b0, b2}, 0);
    chk("rst_err", {31'b0, e2}, 0);
    chk("rst_word", {27'b0, dev2, a2, dt2}, 0);
    reset = 0; w(5); clr();
    cs_low(); bits(32, 256'h0A050C01); cs_high(20);
    chk("good_nv", qw.size(), 2);
    chk("good_err", ne, 0);
    chk("good_done", nd, 1);
    if (qw.size() == 2) begin
      chk("good_w0", qw[0], ew(0, 0, 'hC, 'h01));
      chk("good_w1", qw[1], ew(1, 1, 'hA, 'h05));
      chk("good_gap", qc[1] - qc[0], 1);
    end
    clr(); cs_low(); bits(20, 256'hABCDE); cs_high(20);
    chk("len20_nv", qw.size(), 0);
    chk("len20_err", ne, 1);
    clr(); cs_low(); bits(48, 256'h0A050C010B07); cs_high(20);
    chk("len48_nv", qw.size(), 0);
    chk("len48_err", ne, 1);
    clr();
    for (int i = 0; i < 50; i++) begin
      mosi = 1'($urandom); sck = 1; w(4); sck = 0; w(4);
    end
    chk("noise_busy", {31'b0, b2}, 0);
    cs = 0; w(8);
    chk("cs_busy", {31'b0, b2}, 1);
    cs = 1; w(20);
    chk("noise_nv", qw.size(), 0);
    chk("noise_err", ne, 0);
    chk("noise_idle", {31'b0, b2}, 0);
    sel = 1; w(10); clr();
    cs_low(); bits(256, fa); cs_high(4);
    cs_low(); bits(256, fb); cs_high(40);
    chk("b2b_nv", qw.size(), 32);
    chk("b2b_done", nd, 2);
    chk("b2b_err", ne, 0);
    if (qw.size() == 32) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("b2b_a%0d", k), qw[k], ew(k == 15, k, 'hA, 'h0F));
        chk($sformatf("b2b_b%0d", k), qw[16 + k], ew(k == 15, k, (k % 8) + 1, k * 17));
      end
      chk("b2b_gap", qc[15] - qc[0], 15);
    end
    clr(); cs_low(); bits(100, fa);
    reset = 1; w(3); reset = 0; w(2);
    cs_high(10);
    cs_low(); bits(256, fb); cs_high(40);
    chk("rstf_nv", qw.size(), 16);
    chk("rstf_err", ne, 0);
    chk("rstf_done", nd, 1);
    if (qw.size() == 16) begin
      chk("rstf_w0", qw[0], ew(0, 0, 1, 0));
      chk("rstf_w15", qw[15], ew(1, 15, 8, 255));
    end
    clr(); cs_low(); bits(256, fa); w(4); cs = 1;
    begin
      int seen = 0;
      for (int i = 0; i < 100 && seen < 3; i++) begin
        @(negedge clk);
        if (v16) seen++;
      end
      chk("rste_seen", seen, 3);
    end
    reset = 1; w(20); reset = 0; w(10);
    chk("rste_nv", qw.size(), 3);
    chk("rste_done", nd, 0);
    chk("rste_busy", {31'b0, b16}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
